fp_mul_seq: RTL and testbench



---
 rtl/fp_mul_seq.sv | 146 ++++++++++++++
 tb/tb_fp_mul_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add mantissa product, one bit per cycle,
// then a one-cycle normalize/round/pack step; result held until the consumer accepts it.
module fp_mul_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] a,
  input  logic [EXP_W+MANT_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] result,
  output logic                    flag_inf,
  output logic                    flag_zero
);

  localparam int DW   = EXP_W + MANT_W;
  localparam int FW   = MANT_W - 1;
  localparam int PW   = 2 * MANT_W;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(MANT_W);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [EW-1:0] E_MAX = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   sign;
  logic [MANT_W-1:0]      a_m, b_m;
  logic [PW-1:0]          prod;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   e_sum;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic             in_sign, any_max, any_zero;

  assign a_exp    = a[DW-2 -: EXP_W];
  assign b_exp    = b[DW-2 -: EXP_W];
  assign in_sign  = a[DW-1] ^ b[DW-1];
  assign any_max  = (&a_exp) | (&b_exp);
  assign any_zero = (a_exp == '0) | (b_exp == '0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (any_max | any_zero) ? DONE : MUL;
      end
      MUL:  if (cnt == '0) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Normalize, round to nearest even, and detect exponent range on the finished product.
  logic [FW-1:0]        frac_t, frac_r;
  logic [FW:0]          frac_sum;
  logic                 guard, sticky, rnd;
  logic signed [EW-1:0] e_n, e_r;

  always_comb begin
    if (prod[PW-1]) begin
      frac_t = prod[PW-2:MANT_W];
      guard  = prod[MANT_W-1];
      sticky = |prod[MANT_W-2:0];
      e_n    = e_sum + E_ONE;
    end else begin
      frac_t = prod[PW-3:MANT_W-1];
      guard  = prod[MANT_W-2];
      sticky = |prod[MANT_W-3:0];
      e_n    = e_sum;
    end
    rnd      = guard & (sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + {{FW{1'b0}}, rnd};
    e_r      = e_n + (frac_sum[FW] ? E_ONE : '0);
    frac_r   = frac_sum[FW] ? '0 : frac_sum[FW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      a_m       <= '0;
      b_m       <= '0;
      prod      <= '0;
      cnt       <= '0;
      e_sum     <= '0;
      result    <= '0;
      flag_inf  <= 1'b0;
      flag_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          sign  <= in_sign;
          a_m   <= {1'b1, a[FW-1:0]};
          b_m   <= {1'b1, b[FW-1:0]};
          e_sum <= EW'({2'b00, a_exp}) + EW'({2'b00, b_exp}) - EW'(BIAS);
          prod  <= '0;
          cnt   <= CW'(MANT_W - 1);
          if (any_max) begin
            result   <= {in_sign, {EXP_W{1'b1}}, {FW{1'b0}}};
            flag_inf <= 1'b1;
          end else if (any_zero) begin
            result    <= {in_sign, {(DW-1){1'b0}}};
            flag_zero <= 1'b1;
          end
        end
        MUL: begin
          // MSB-first: shift the partial product and add the multiplicand when the bit is set.
          if (b_m[cnt]) prod <= {prod[PW-2:0], 1'b0} + {{MANT_W{1'b0}}, a_m};
          else          prod <= {prod[PW-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        NORM: begin
          if (e_r >= E_MAX) begin
            result   <= {sign, {EXP_W{1'b1}}, {FW{1'b0}}};
            flag_inf <= 1'b1;
          end else if (e_r < E_ONE) begin
            result    <= {sign, {(DW-1){1'b0}}};
            flag_zero <= 1'b1;
          end else begin
            result <= {sign, e_r[EXP_W-1:0], frac_r};
          end
        end
        DONE: if (out_ready) begin
          flag_inf  <= 1'b0;
          flag_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: scoreboard of expected results, latency, backpressure and reset checks.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flag_inf, flag_zero;
  logic [31:0] a, b, result;

  typedef struct {
    logic [31:0] res;
    logic        inf;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fp_mul_seq #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_inf(flag_inf), .flag_zero(flag_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic fi, input logic fz);
    int n;
    sb.push_back('{r, fi, fz});
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_at_send", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc + 1, exp_lat);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"},  result, e.res);
      check({tag, "_inf"},  {31'b0, flag_inf},  {31'b0, e.inf});
      check({tag, "_zero"}, {31'b0, flag_zero}, {31'b0, e.zero});
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_fall"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ir_rise"}, {31'b0, in_ready},  32'd1);
    check({tag, "_flags_clr"}, {30'b0, flag_inf, flag_zero}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result, 32'h0);
    check("rst_flags",     {30'b0, flag_inf, flag_zero}, 32'd0);
    rst = 1'b0;

    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    collect("one_x_one", 26);
    handshake("one_x_one");

    send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    collect("1p5_x_2", 26);
    handshake("1p5_x_2");

    send(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);
    collect("m2_x_3", 26);
    handshake("m2_x_3");

    send(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
    collect("zero_op", 1);
    handshake("zero_op");

    send(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0);
    collect("inf_op", 1);
    handshake("inf_op");

    send(32'h7F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0);
    collect("inf_x_mzero", 1);
    handshake("inf_x_mzero");

    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
    collect("overflow", 26);
    handshake("overflow");

    send(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
    collect("underflow", 26);
    handshake("underflow");

    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
    collect("sticky_round", 26);
    handshake("sticky_round");

    // Exact ties: odd lsb rounds up, even lsb stays.
    send(32'h40400000, 32'h3F800001, 32'h40400002, 1'b0, 1'b0);
    collect("tie_up", 26);
    handshake("tie_up");

    send(32'h40400000, 32'h3F800003, 32'h40400004, 1'b0, 1'b0);
    collect("tie_even", 26);
    handshake("tie_even");

    send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    collect("bp", 26);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = 32'h3F800000;
      @(posedge clk);
      #1;
      check("bp_result",   result, 32'h40400000);
      check("bp_out_vld",  {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(posedge clk);
    #1;
    check("bp_no_accept", {31'b0, in_ready}, 32'd1);

    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result",    result, 32'h0);
    repeat (30) @(posedge clk);
    #1;
    check("midrst_dropped", {31'b0, out_valid}, 32'd0);

    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    collect("after_rst", 26);
    handshake("after_rst");

    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
